multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multicycle main control FSM plus ALU decoder that sequences the 32-bit MIPS datapath.
- The datapath uses one shared instruction/data memory, an instruction register, and a PC with write enable.
- Decodes opcode/funct and drives every mux select and write enable, one instruction phase per cycle.
- Stalls on a memory-ready handshake.

Parameters:
- STATE_W, 4, width of state register (12 states used).

Ports:
- CLK  in  1  system clock, rising edge.
- Reset  in  1  synchronous, active-high reset.
- Op  in  6  Instr[31:26] from the instruction register.
- Funct  in  6  Instr[5:0] from the instruction register.
- Zero  in  1  ALU zero flag.
- MemReady  in  1  memory completed the current access this cycle.
- MemReq  out  1  memory access request.
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- PCEn  out  1  PC load; equals PCWrite | (Branch & Zero).
- PCSrc  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- ALUSrcA  out  1  0 = PC, 1 = register A.
- ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = SignImm, 11 = SignImm<<2.
- ALUControl  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt.
- RegDst  out  1  0 = rt, 1 = rd.
- MemtoReg  out  1  0 = ALUOut, 1 = memory data.
- RegWrite  out  1  register file write enable.
- Illegal  out  1  one-cycle pulse on unsupported opcode.

Behaviour:
- Outputs are Moore decodes of state, except PCEn (uses Zero), handshake-gated strobes, and ALUControl (uses Funct in EXECUTE).
- Reset:
  - On a CLK edge with Reset=1, state <= FETCH.
  - While Reset=1, MemWrite, IRWrite, PCEn, RegWrite, MemReq and Illegal are forced 0.
  - Reset mid-instruction abandons it; no partial register or memory write occurs on or after that edge.
- States and actions:
  - FETCH: MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=010, PCSrc=00. IRWrite=PCWrite=MemReady. Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUControl=010 (branch target into ALUOut). Next state by Op:
    - lw/sw -> MEMADR
    - R-type -> EXECUTE
    - beq -> BRANCH
    - addi -> ADDIEXEC
    - j -> JUMP
    - otherwise Illegal=1 for this cycle, next state FETCH (treated as nop).
  - MEMADR: ALUSrcA=1, ALUSrcB=10, add. Next: MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: MemReq=1, IorD=1. Waits for MemReady, then MEMWB.
  - MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. Next: FETCH.
  - MEMWRITE: MemReq=1, IorD=1, MemWrite=1 held until MemReady. Next: FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUControl from Funct. Next: ALUWB.
  - ALUWB: RegWrite=1, RegDst=1, MemtoReg=0. Next: FETCH.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, sub, Branch=1, PCSrc=01. Next: FETCH.
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10, add. Next: ADDIWB.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. Next: FETCH.
  - JUMP: PCSrc=10, PCWrite=1. Next: FETCH.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- Funct (R-type, EXECUTE only):
  - 100000 add -> 010
  - 100010 sub -> 110
  - 100100 and -> 000
  - 100101 or -> 001
  - 101010 slt -> 111
  - any other funct -> 010 (add), no Illegal.
- Signals not listed for a state default to 0; ALUControl defaults to 010.
- Latency with MemReady tied 1 (cycles per instruction):
  - beq 3, j 3
  - R-type 4, addi 4, sw 4
  - lw 5
  - illegal 2
  - Each MemReady=0 cycle adds one cycle to FETCH, MEMREAD or MEMWRITE.
- Simultaneous events:
  - Zero is ignored outside BRANCH.
  - MemReady is ignored when MemReq=0.
  - Reset dominates MemReady.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - state enumeration / localparams
  - opcode and funct constants
  - ALUControl codes
  - PCSrc and ALUSrcB encodings
- One sub-module: alu_decoder (inputs ALUOp[1:0] and Funct, output ALUControl). The FSM drives ALUOp: 00 add, 01 sub, 10 funct.

Test Plan:
- Reset held 3 cycles mid-lw (state MEMREAD) -> RegWrite/MemWrite stay 0; first cycle after release is FETCH with MemReq=1, IorD=0.
- Op=000000, Funct=100010, MemReady=1 -> states FETCH, DECODE, EXECUTE, ALUWB; ALUControl=110 in EXECUTE; RegWrite=1, RegDst=1 only in ALUWB; 4 cycles.
- lw with MemReady low 2 cycles in FETCH and 3 in MEMREAD -> 10 cycles total; IRWrite and PCEn pulse once, only on the MemReady cycle; RegWrite=1, MemtoReg=1 in MEMWB.
- beq with Zero=1, then Zero=0 -> PCEn=1 / PCEn=0 in BRANCH, PCSrc=01, ALUControl=110; 3 cycles each.
- Op=000010 -> PCEn=1, PCSrc=10 in JUMP. Op=111111 -> Illegal=1 for one cycle in DECODE, then FETCH, with no RegWrite/MemWrite.
- sw, MemReady=0 for 2 cycles -> MemWrite=1, IorD=1 for 3 consecutive cycles, then FETCH.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_ctrl_pkg
// Description : Shared definitions for the multicycle MIPS controller:
//               FSM state encoding, opcode/funct values, ALUControl codes,
//               ALUOp codes, PCSrc and ALUSrcB mux encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

    localparam int ST_W = 4;

    typedef enum logic [ST_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // Opcodes (Instr[31:26])
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;

    // R-type funct field (Instr[5:0])
    localparam logic [5:0] c_FN_ADD = 6'b100000;
    localparam logic [5:0] c_FN_SUB = 6'b100010;
    localparam logic [5:0] c_FN_AND = 6'b100100;
    localparam logic [5:0] c_FN_OR  = 6'b100101;
    localparam logic [5:0] c_FN_SLT = 6'b101010;

    // ALUControl codes
    localparam logic [2:0] c_ALU_ADD = 3'b010;
    localparam logic [2:0] c_ALU_SUB = 3'b110;
    localparam logic [2:0] c_ALU_AND = 3'b000;
    localparam logic [2:0] c_ALU_OR  = 3'b001;
    localparam logic [2:0] c_ALU_SLT = 3'b111;

    // ALUOp from FSM to ALU decoder
    localparam logic [1:0] c_ALUOP_ADD   = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB   = 2'b01;
    localparam logic [1:0] c_ALUOP_FUNCT = 2'b10;

    // PCSrc encodings
    localparam logic [1:0] c_PCSRC_ALURES = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    // ALUSrcB encodings
    localparam logic [1:0] c_SRCB_REG   = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
    localparam logic [1:0] c_SRCB_IMM   = 2'b10;
    localparam logic [1:0] c_SRCB_IMMSH = 2'b11;

endpackage
`default_nettype wire

// File: rtl/multicycle_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller_if
// Description : Controller <-> datapath bundle.
//               master : controller side (drives mux selects / strobes)
//               slave  : datapath side (drives Op, Funct, Zero, MemReady)
// Revision    : 1.0 - initial release
// ============================================================================
interface multicycle_controller_if;

    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       MemReady;

    logic       MemReq;
    logic       IorD;
    logic       MemWrite;
    logic       IRWrite;
    logic       PCEn;
    logic [1:0] PCSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic       RegDst;
    logic       MemtoReg;
    logic       RegWrite;
    logic       Illegal;

    modport master (
        input  Op, Funct, Zero, MemReady,
        output MemReq, IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA,
               ALUSrcB, ALUControl, RegDst, MemtoReg, RegWrite, Illegal
    );

    modport slave (
        output Op, Funct, Zero, MemReady,
        input  MemReq, IorD, MemWrite, IRWrite, PCEn, PCSrc, ALUSrcA,
               ALUSrcB, ALUControl, RegDst, MemtoReg, RegWrite, Illegal
    );

endinterface
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_decoder
// Description : Maps ALUOp (from the FSM) and Funct to ALUControl.
//               alu_op 00 -> add, 01 -> sub, 10 -> decode funct.
//               Unknown funct (and unused alu_op 11) fall back to add.
// Ports       : alu_op[1:0] in, funct[5:0] in, alu_control[2:0] out
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = c_ALU_ADD;
        case (alu_op)
            c_ALUOP_SUB: alu_control = c_ALU_SUB;
            c_ALUOP_FUNCT: begin
                case (funct)
                    c_FN_SUB: alu_control = c_ALU_SUB;
                    c_FN_AND: alu_control = c_ALU_AND;
                    c_FN_OR:  alu_control = c_ALU_OR;
                    c_FN_SLT: alu_control = c_ALU_SLT;
                    default:  alu_control = c_ALU_ADD;
                endcase
            end
            default: alu_control = c_ALU_ADD;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Main control FSM for the multicycle MIPS datapath. One
//               instruction phase per cycle; stalls FETCH/MEMREAD/MEMWRITE
//               until MemReady.
// Ports       : CLK   - clock, rising edge
//               Reset - synchronous active-high reset
//               ctl   - controller bundle (master modport)
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic                    CLK,
    input  logic                    Reset,
    multicycle_controller_if.master ctl
);

    logic [STATE_W-1:0] r_state;
    state_t             w_state;
    state_t             w_next;

    logic       w_mem_req;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_branch;
    logic       w_reg_write;
    logic       w_illegal;
    logic [1:0] w_alu_op;

    assign w_state = state_t'(r_state[ST_W-1:0]);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= STATE_W'(S_FETCH);
        end else begin
            r_state <= STATE_W'(w_next);
        end
    end

    always_comb begin
        w_next          = w_state;
        w_mem_req       = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_pc_write      = 1'b0;
        w_branch        = 1'b0;
        w_reg_write     = 1'b0;
        w_illegal       = 1'b0;
        w_alu_op        = c_ALUOP_ADD;
        ctl.IorD        = 1'b0;
        ctl.PCSrc       = c_PCSRC_ALURES;
        ctl.ALUSrcA     = 1'b0;
        ctl.ALUSrcB     = c_SRCB_REG;
        ctl.RegDst      = 1'b0;
        ctl.MemtoReg    = 1'b0;
        case (w_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                ctl.ALUSrcB = c_SRCB_FOUR;
                // IR load and PC+4 commit only on the cycle memory returns
                w_ir_write  = ctl.MemReady;
                w_pc_write  = ctl.MemReady;
                if (ctl.MemReady) w_next = S_DECODE;
            end
            S_DECODE: begin
                // Precompute branch target into ALUOut
                ctl.ALUSrcB = c_SRCB_IMMSH;
                case (ctl.Op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE:       w_next = S_EXECUTE;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_ADDI:        w_next = S_ADDIEXEC;
                    c_OP_J:           w_next = S_JUMP;
                    default: begin
                        w_illegal = 1'b1;
                        w_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctl.ALUSrcA = 1'b1;
                ctl.ALUSrcB = c_SRCB_IMM;
                w_next      = (ctl.Op == c_OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                w_mem_req = 1'b1;
                ctl.IorD  = 1'b1;
                if (ctl.MemReady) w_next = S_MEMWB;
            end
            S_MEMWB: begin
                w_reg_write  = 1'b1;
                ctl.MemtoReg = 1'b1;
                w_next       = S_FETCH;
            end
            S_MEMWRITE: begin
                w_mem_req   = 1'b1;
                w_mem_write = 1'b1;
                ctl.IorD    = 1'b1;
                if (ctl.MemReady) w_next = S_FETCH;
            end
            S_EXECUTE: begin
                ctl.ALUSrcA = 1'b1;
                w_alu_op    = c_ALUOP_FUNCT;
                w_next      = S_ALUWB;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                ctl.RegDst  = 1'b1;
                w_next      = S_FETCH;
            end
            S_BRANCH: begin
                ctl.ALUSrcA = 1'b1;
                w_alu_op    = c_ALUOP_SUB;
                w_branch    = 1'b1;
                ctl.PCSrc   = c_PCSRC_ALUOUT;
                w_next      = S_FETCH;
            end
            S_ADDIEXEC: begin
                ctl.ALUSrcA = 1'b1;
                ctl.ALUSrcB = c_SRCB_IMM;
                w_next      = S_ADDIWB;
            end
            S_ADDIWB: begin
                w_reg_write = 1'b1;
                w_next      = S_FETCH;
            end
            S_JUMP: begin
                ctl.PCSrc  = c_PCSRC_JUMP;
                w_pc_write = 1'b1;
                w_next     = S_FETCH;
            end
            default: w_next = S_FETCH;
        endcase
    end

    // Strobes are masked during reset so an abandoned instruction can
    // never commit a register, memory, IR or PC write.
    assign ctl.MemReq   = w_mem_req   & ~Reset;
    assign ctl.MemWrite = w_mem_write & ~Reset;
    assign ctl.IRWrite  = w_ir_write  & ~Reset;
    assign ctl.RegWrite = w_reg_write & ~Reset;
    assign ctl.Illegal  = w_illegal   & ~Reset;
    assign ctl.PCEn     = (w_pc_write | (w_branch & ctl.Zero)) & ~Reset;

    alu_decoder u_alu_decoder (
        .alu_op      (w_alu_op),
        .funct       (ctl.Funct),
        .alu_control (ctl.ALUControl)
    );

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Directed bench for multicycle_controller. Each cycle the full
//               control word is compared with a hand-computed constant.
//               Word order: MemReq,IorD,MemWrite,IRWrite,PCEn,PCSrc[1:0],
//               ALUSrcA,ALUSrcB[1:0],ALUControl[2:0],RegDst,MemtoReg,
//               RegWrite,Illegal
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

    logic CLK   = 1'b0;
    logic Reset = 1'b1;

    multicycle_controller_if bus();

    multicycle_controller #(.STATE_W(4)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .ctl   (bus)
    );

    always #5 CLK = ~CLK;

    //                                      Rq I  W  IR PE PCS A  SB  ALU  Rd M2R RW Il
    localparam logic [17:0] W_FETCH_GO   = 18'b1_0_0_1_1_00_0_01_010_0_0_0_0;
    localparam logic [17:0] W_FETCH_WAIT = 18'b1_0_0_0_0_00_0_01_010_0_0_0_0;
    localparam logic [17:0] W_FETCH_RST  = 18'b0_0_0_0_0_00_0_01_010_0_0_0_0;
    localparam logic [17:0] W_DECODE     = 18'b0_0_0_0_0_00_0_11_010_0_0_0_0;
    localparam logic [17:0] W_ILLEGAL    = 18'b0_0_0_0_0_00_0_11_010_0_0_0_1;
    localparam logic [17:0] W_ADDR_CALC  = 18'b0_0_0_0_0_00_1_10_010_0_0_0_0;
    localparam logic [17:0] W_MEMREAD    = 18'b1_1_0_0_0_00_0_00_010_0_0_0_0;
    localparam logic [17:0] W_MEMREAD_RS = 18'b0_1_0_0_0_00_0_00_010_0_0_0_0;
    localparam logic [17:0] W_MEMWB      = 18'b0_0_0_0_0_00_0_00_010_0_1_1_0;
    localparam logic [17:0] W_MEMWRITE   = 18'b1_1_1_0_0_00_0_00_010_0_0_0_0;
    localparam logic [17:0] W_ALUWB      = 18'b0_0_0_0_0_00_0_00_010_1_0_1_0;
    localparam logic [17:0] W_BR_TAKEN   = 18'b0_0_0_0_1_01_1_00_110_0_0_0_0;
    localparam logic [17:0] W_BR_NOT     = 18'b0_0_0_0_0_01_1_00_110_0_0_0_0;
    localparam logic [17:0] W_ADDIWB     = 18'b0_0_0_0_0_00_0_00_010_0_0_1_0;
    localparam logic [17:0] W_JUMP       = 18'b0_0_0_0_1_10_0_00_010_0_0_0_0;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [17:0] ctl_word();
        return {bus.MemReq, bus.IorD, bus.MemWrite, bus.IRWrite, bus.PCEn,
                bus.PCSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                bus.RegDst, bus.MemtoReg, bus.RegWrite, bus.Illegal};
    endfunction

    // EXECUTE word: only ALUControl varies with Funct
    function automatic logic [17:0] exec_word(input logic [2:0] aluc);
        return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 2'b00, aluc,
                1'b0, 1'b0, 1'b0, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b", tag, obs[17:0], exp[17:0]);
        end
    endtask

    // Apply MemReady/Zero for one cycle, check the word mid-cycle, then
    // step past the next rising edge.
    task automatic tick(input string tag, input logic ready, input logic zero,
                        input logic [17:0] exp);
        bus.MemReady = ready;
        bus.Zero     = zero;
        #2;
        check(tag, {14'd0, ctl_word()}, {14'd0, exp});
        @(posedge CLK);
        #1;
    endtask

    logic [5:0] fn_tab  [5];
    logic [2:0] alu_tab [5];

    initial begin
        fn_tab[0] = 6'b100000; alu_tab[0] = 3'b010;
        fn_tab[1] = 6'b100100; alu_tab[1] = 3'b000;
        fn_tab[2] = 6'b100101; alu_tab[2] = 3'b001;
        fn_tab[3] = 6'b101010; alu_tab[3] = 3'b111;
        fn_tab[4] = 6'b000111; alu_tab[4] = 3'b010;

        bus.Op       = 6'b000000;
        bus.Funct    = 6'b000000;
        bus.Zero     = 1'b0;
        bus.MemReady = 1'b1;

        // Reset: FETCH decode with all strobes masked
        repeat (2) @(posedge CLK);
        #1;
        tick("reset_fetch", 1'b1, 1'b0, W_FETCH_RST);
        Reset = 1'b0;

        // R-type sub: 4 cycles
        bus.Op = 6'b000000; bus.Funct = 6'b100010;
        tick("sub_fetch",  1'b1, 1'b0, W_FETCH_GO);
        tick("sub_decode", 1'b1, 1'b0, W_DECODE);
        tick("sub_exec",   1'b1, 1'b0, exec_word(3'b110));
        tick("sub_aluwb",  1'b1, 1'b0, W_ALUWB);

        // Remaining funct codes, including an unknown one
        for (int i = 0; i < 5; i++) begin
            bus.Funct = fn_tab[i];
            tick("rt_fetch",  1'b1, 1'b0, W_FETCH_GO);
            tick("rt_decode", 1'b1, 1'b0, W_DECODE);
            tick("rt_exec",   1'b1, 1'b0, exec_word(alu_tab[i]));
            tick("rt_aluwb",  1'b1, 1'b0, W_ALUWB);
        end

        // lw: 2 wait cycles in FETCH, 3 in MEMREAD -> 10 cycles
        bus.Op = 6'b100011; bus.Funct = 6'b000000;
        tick("lw_fetch_w0", 1'b0, 1'b0, W_FETCH_WAIT);
        tick("lw_fetch_w1", 1'b0, 1'b0, W_FETCH_WAIT);
        tick("lw_fetch",    1'b1, 1'b0, W_FETCH_GO);
        tick("lw_decode",   1'b1, 1'b0, W_DECODE);
        tick("lw_memadr",   1'b1, 1'b0, W_ADDR_CALC);
        tick("lw_rd_w0",    1'b0, 1'b0, W_MEMREAD);
        tick("lw_rd_w1",    1'b0, 1'b0, W_MEMREAD);
        tick("lw_rd_w2",    1'b0, 1'b0, W_MEMREAD);
        tick("lw_rd",       1'b1, 1'b0, W_MEMREAD);
        tick("lw_memwb",    1'b1, 1'b0, W_MEMWB);

        // beq taken; Zero held high throughout must not matter outside BRANCH
        bus.Op = 6'b000100;
        tick("beqt_fetch",  1'b1, 1'b1, W_FETCH_GO);
        tick("beqt_decode", 1'b1, 1'b1, W_DECODE);
        tick("beqt_branch", 1'b1, 1'b1, W_BR_TAKEN);
        // beq not taken
        tick("beqn_fetch",  1'b1, 1'b0, W_FETCH_GO);
        tick("beqn_decode", 1'b1, 1'b0, W_DECODE);
        tick("beqn_branch", 1'b1, 1'b0, W_BR_NOT);

        // j
        bus.Op = 6'b000010;
        tick("j_fetch",  1'b1, 1'b0, W_FETCH_GO);
        tick("j_decode", 1'b1, 1'b0, W_DECODE);
        tick("j_jump",   1'b1, 1'b0, W_JUMP);

        // illegal opcode: 2 cycles, Illegal pulse in DECODE only
        bus.Op = 6'b111111;
        tick("ill_fetch",  1'b1, 1'b0, W_FETCH_GO);
        tick("ill_decode", 1'b1, 1'b0, W_ILLEGAL);

        // sw with 2 wait cycles in MEMWRITE
        bus.Op = 6'b101011;
        tick("sw_fetch",  1'b1, 1'b0, W_FETCH_GO);
        tick("sw_decode", 1'b1, 1'b0, W_DECODE);
        tick("sw_memadr", 1'b1, 1'b0, W_ADDR_CALC);
        tick("sw_wr_w0",  1'b0, 1'b0, W_MEMWRITE);
        tick("sw_wr_w1",  1'b0, 1'b0, W_MEMWRITE);
        tick("sw_wr",     1'b1, 1'b0, W_MEMWRITE);

        // addi
        bus.Op = 6'b001000;
        tick("addi_fetch",  1'b1, 1'b0, W_FETCH_GO);
        tick("addi_decode", 1'b1, 1'b0, W_DECODE);
        tick("addi_exec",   1'b1, 1'b0, W_ADDR_CALC);
        tick("addi_wb",     1'b1, 1'b0, W_ADDIWB);

        // Reset held 3 cycles while lw sits in MEMREAD; MemReady=1 during
        // reset must not advance to MEMWB
        bus.Op = 6'b100011;
        tick("rlw_fetch",  1'b1, 1'b0, W_FETCH_GO);
        tick("rlw_decode", 1'b1, 1'b0, W_DECODE);
        tick("rlw_memadr", 1'b1, 1'b0, W_ADDR_CALC);
        tick("rlw_rd_w0",  1'b0, 1'b0, W_MEMREAD);
        Reset = 1'b1;
        tick("rlw_rst0",   1'b1, 1'b0, W_MEMREAD_RS);
        tick("rlw_rst1",   1'b1, 1'b0, W_FETCH_RST);
        tick("rlw_rst2",   1'b1, 1'b0, W_FETCH_RST);
        Reset = 1'b0;
        tick("rlw_after",  1'b0, 1'b0, W_FETCH_WAIT);
        tick("rlw_after1", 1'b1, 1'b0, W_FETCH_GO);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
